// File: rtl/twdl_idx_gen.sv
// twdl_idx_gen: per-butterfly twiddle numerator/denominator sequencer for one mixed-radix FFT stage.
// Optional inverse-FFT conjugate numerators when TWDL_IDX_INV_EN is defined (adds cfg_inverse).
module twdl_idx_gen #(
  parameter int wIdx  = 12,
  parameter int nLane = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_load,
  input  logic [2:0]                      cfg_factor,
  input  logic [wIdx-1:0]                 cfg_span,
  input  logic [wIdx-1:0]                 cfg_blocks,
`ifdef TWDL_IDX_INV_EN
  input  logic                            cfg_inverse,
`endif
  input  logic                            bfly_val,
  output logic [2:0]                      factor,
  output logic [0:nLane-1][wIdx-1:0]      twdl_numrtr,
  output logic [wIdx-1:0]                 twdl_demontr,
  output logic                            out_val,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [wIdx-1:0] span_q, blocks_q, m_q, blk_q;
  logic [0:nLane-1][wIdx-1:0] acc, lane_val;
  logic [wIdx+2:0] prod;
  logic legal, accept, reject, step, m_wrap, last, inv;
  assign prod   = {{wIdx{1'b0}}, cfg_factor} * {3'b000, cfg_span};
  assign legal  = (cfg_factor >= 3'd2) && (cfg_factor <= 3'd5) && (cfg_span != '0) &&
                  (cfg_blocks != '0) && (prod[wIdx+2:wIdx] == 3'b000);
  assign accept = (state_q == IDLE) && cfg_load && legal;
  assign reject = (state_q == IDLE) && cfg_load && !legal;
  assign step   = (state_q == RUN) && bfly_val;
  assign m_wrap = m_q == span_q - wIdx'(1);
  assign last   = step && m_wrap && (blk_q == blocks_q - wIdx'(1));
  assign busy   = state_q == RUN;
`ifdef TWDL_IDX_INV_EN
  logic inv_q;
  assign inv = inv_q;
`else
  assign inv = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    state_d = accept ? RUN : (last ? IDLE : state_q);
  end
  // Inverse lanes are the conjugate index R*L - p*m, with index 0 mapping to itself
  genvar p;
  generate
    for (p = 0; p < nLane; p++) begin : g_lane
      assign lane_val[p] = (3'(p) >= factor) ? '0 :
                           (inv && acc[p] != '0) ? twdl_demontr - acc[p] : acc[p];
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      factor       <= '0;
      span_q       <= '0;
      blocks_q     <= '0;
      twdl_demontr <= '0;
      m_q          <= '0;
      blk_q        <= '0;
      acc          <= '0;
      twdl_numrtr  <= '0;
      out_val      <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
`ifdef TWDL_IDX_INV_EN
      inv_q        <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_val <= step;
      done    <= last;
      cfg_err <= reject;
      if (accept) begin
        factor       <= cfg_factor;
        span_q       <= cfg_span;
        blocks_q     <= cfg_blocks;
        twdl_demontr <= prod[wIdx-1:0];
        m_q          <= '0;
        blk_q        <= '0;
        acc          <= '0;
`ifdef TWDL_IDX_INV_EN
        inv_q        <= cfg_inverse;
`endif
      end
      if (step) begin
        twdl_numrtr <= lane_val;
        m_q         <= m_wrap ? '0 : m_q + wIdx'(1);
        blk_q       <= m_wrap ? blk_q + wIdx'(1) : blk_q;
        for (int i = 0; i < nLane; i++)
          acc[i] <= m_wrap ? '0 : acc[i] + wIdx'(i);
      end
    end
  end
endmodule
